// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, address type and writability helper
package regfile_pkg;

    localparam int NUM_REGS         = 32;
    localparam int ADDR_W           = 5;
    localparam int ZERO_REG_DEFAULT = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    function automatic logic writable(input reg_addr_t addr, input logic has_zero,
                                      input reg_addr_t zero_reg);
        return !(has_zero && (addr == zero_reg));
    endfunction

endpackage

// File: rtl/regfile_write_bank_if.sv
// rtl/regfile_write_bank_if.sv - write-port and flattened-contents bus of the register file
interface regfile_write_bank_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64
);
    logic                       wr_en;
    reg_addr_t                  wr_addr;
    logic [WIDTH-1:0]           wr_data;
    logic [NUM_REGS-1:0]        wr_onehot;
    logic [NUM_REGS*WIDTH-1:0]  regs_out;
    logic                       wr_ack;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  wr_onehot, regs_out, wr_ack
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output wr_onehot, regs_out, wr_ack
    );
endinterface

// File: rtl/regfile_write_bank_demux1x2.sv
// rtl/regfile_write_bank_demux1x2.sv - 1:2 demultiplexer cell, dual of the 2:1 mux cell
module demux1x2 (
    input  logic in,
    input  logic s,
    output logic a,
    output logic b
);
    assign a = in & ~s;
    assign b = in &  s;
endmodule

// File: rtl/regfile_write_bank.sv
// rtl/regfile_write_bank.sv - 32-entry register-file write bank with demux-tree address decoder
module regfile_write_bank
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int HAS_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_bank_if.slave  bus
);

    // Heap-ordered tree: node n feeds 2n and 2n+1; leaves 32..63 map to registers 0..31.
    logic [2*NUM_REGS-1:1] node;
    logic [NUM_REGS-1:0]   wr_onehot;
    logic                  wr_ack_d;
    logic                  wr_ack_q;

    assign node[1] = bus.wr_en & reset;

    generate
        for (genvar n = 1; n < NUM_REGS; n++) begin : g_tree
            localparam int DEPTH = $clog2(n + 1) - 1;
            demux1x2 u_demux (
                .in (node[n]),
                .s  (bus.wr_addr[ADDR_W-1-DEPTH]),
                .a  (node[2*n]),
                .b  (node[2*n+1])
            );
        end

        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            localparam logic WR = writable(reg_addr_t'(r), HAS_ZERO != 0, reg_addr_t'(ZERO_REG));

            assign wr_onehot[r] = node[NUM_REGS+r] & WR;

            if (WR) begin : g_rw
                logic [WIDTH-1:0] reg_d;
                logic [WIDTH-1:0] reg_q;

                always_comb begin
                    reg_d = reg_q;
                    if (wr_onehot[r]) reg_d = bus.wr_data;
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) reg_q <= '0;
                    else        reg_q <= reg_d;
                end

                assign bus.regs_out[r*WIDTH +: WIDTH] = reg_q;
            end else begin : g_zero
                assign bus.regs_out[r*WIDTH +: WIDTH] = '0;
            end
        end
    endgenerate

    // A committed write is exactly a set decoder leaf, so X on wr_addr while idle cannot ack.
    always_comb begin
        wr_ack_d = |wr_onehot;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wr_ack_q <= 1'b0;
        else        wr_ack_q <= wr_ack_d;
    end

    assign bus.wr_onehot = wr_onehot;
    assign bus.wr_ack    = wr_ack_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// tb/tb_regfile_write_bank.sv - scoreboard bench for regfile_write_bank (HAS_ZERO=1 and HAS_ZERO=0)
module tb_regfile_write_bank;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        ack;
        logic        en;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;

    int checks;
    int errors;
    logic [63:0] model [32];
    exp_t        exp_q [$];

    regfile_write_bank_if #(.WIDTH(64)) bus0 ();
    regfile_write_bank_if #(.WIDTH(64)) bus1 ();

    assign bus0.wr_en   = wr_en;
    assign bus0.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data;
    assign bus1.wr_en   = wr_en;
    assign bus1.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data;

    regfile_write_bank #(.WIDTH(64), .ZERO_REG(31), .HAS_ZERO(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    regfile_write_bank #(.WIDTH(64), .ZERO_REG(31), .HAS_ZERO(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd0(input int i);
        return bus0.regs_out[i*64 +: 64];
    endfunction

    function automatic logic [63:0] rd1(input int i);
        return bus1.regs_out[i*64 +: 64];
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), rd0(i), model[i]);
    endtask

    // Drive one cycle of stimulus just after a rising edge; score the result after the next edge.
    task automatic drive(input logic en, input logic [4:0] addr, input logic [63:0] data);
        exp_t        e;
        logic [31:0] exp_oh;
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        #1;
        exp_oh = 32'd0;
        if (en === 1'b1 && addr != 5'd31) exp_oh = 32'd1 << addr;
        check("onehot", {32'd0, bus0.wr_onehot}, {32'd0, exp_oh});
        if (en === 1'b1) check("old_value", rd0(addr), model[addr]);
        e.en   = en;
        e.addr = addr;
        e.ack  = (en === 1'b1) && (addr != 5'd31);
        e.data = (en === 1'b1) ? (e.ack ? data : model[addr]) : 64'd0;
        if (e.ack) model[addr] = data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("ack", {63'd0, bus0.wr_ack}, {63'd0, e.ack});
        if (e.en) check("commit", rd0(e.addr), e.data);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 64'd0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset_init");
        check("reset_ack", {63'd0, bus0.wr_ack}, 64'd0);
        reset = 1'b1;

        // Single write to reg5, then confirm nothing else moved.
        drive(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
        check("reg5_val", rd0(5), 64'hDEAD_BEEF_0123_4567);
        check_all("after_w5");
        drive(1'b0, 5'd5, 64'd0);

        // Zero register: dropped on dut0, stored on dut1.
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        check("hz0_onehot_seen", {63'd0, bus1.wr_ack}, 64'd1);
        check("hz0_reg31", rd1(31), 64'hFFFF_FFFF_FFFF_FFFF);
        check("hz1_reg31", rd0(31), 64'd0);

        // Back-to-back writes, last one wins, ack per write.
        drive(1'b1, 5'd3, 64'd1);
        drive(1'b1, 5'd3, 64'd2);
        drive(1'b1, 5'd16, 64'd3);
        check("b2b_reg3", rd0(3), 64'd2);
        check("b2b_reg16", rd0(16), 64'd3);

        // Sweep every writable address to exercise each demux path.
        for (int a = 0; a < 31; a++) drive(1'b1, 5'(a), 64'(a) * 64'h0101);
        drive(1'b0, 5'bxxxxx, 64'hAAAA_5555_AAAA_5555);
        check_all("after_sweep_idle_x");

        // Asynchronous reset mid-cycle with live data and a pending write.
        drive(1'b1, 5'd9, 64'h1234);
        wr_en   = 1'b1;
        wr_addr = 5'd10;
        wr_data = 64'h5678;
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        check_all("async_reset");
        check("async_reset_ack", {63'd0, bus0.wr_ack}, 64'd0);
        check("async_reset_onehot", {32'd0, bus0.wr_onehot}, 64'd0);

        // Write to reg7 whose edge sees reset low is lost.
        wr_addr = 5'd7;
        wr_data = 64'h7777;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr_en = 1'b0;
        #1;
        check("lost_reg7", rd0(7), 64'd0);
        check("lost_ack", {63'd0, bus0.wr_ack}, 64'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 5'd7, 64'h0BAD_F00D);
        check("reg7_after", rd0(7), 64'h0BAD_F00D);
        drive(1'b0, 5'd0, 64'd0);
        check_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
